// File: rtl/alu_multicycle.sv
// Handshaked ALU: single-cycle logic/arith/shift/compare ops plus iterative
// shift-add multiply and restoring unsigned divide/remainder.
module alu_multicycle #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic [1:0]       o_state
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_a;    // MUL: shifting multiplicand; DIV: dividend/quotient shifter
  logic [WIDTH-1:0] r_b;    // MUL: shifting multiplier;   DIV: divisor
  logic [WIDTH-1:0] r_acc;  // MUL: partial product;       DIV: partial remainder
  logic [3:0]       r_op;

  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_single;
  logic             w_multi;
  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]   w_div_trial;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_rem;
  logic [WIDTH-1:0] w_div_quo;
  logic [WIDTH-1:0] w_final;

  // Handshake: an operation is accepted on the rising edge where in_valid && in_ready
  // (in_ready only in IDLE); a result is consumed on the edge where out_valid && out_ready.
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign Result    = r_result;
  assign Zero      = r_zero;
  assign o_state   = r_state;

  always_comb begin
    w_sh     = b[SHW-1:0];
    w_single = '0;
    w_multi  = 1'b0;
    case (ALUOp)
      OP_AND:  w_single = a & b;
      OP_OR:   w_single = a | b;
      OP_ADD:  w_single = a + b;
      OP_SUB:  w_single = a - b;
      OP_NOR:  w_single = ~(a | b);
      OP_XOR:  w_single = a ^ b;
      OP_SLL:  w_single = a << w_sh;
      OP_SRL:  w_single = a >> w_sh;
      OP_SRA:  w_single = $unsigned($signed(a) >>> w_sh);
      OP_SLT:  w_single = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_single = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_MUL, OP_DIVU, OP_REMU: w_multi = 1'b1;
      default: w_single = '0;
    endcase
  end

  // One iteration of each multi-cycle algorithm, evaluated from the working registers.
  always_comb begin
    w_mul_acc   = r_acc + (r_b[0] ? r_a : '0);
    w_div_trial = {r_acc, r_a[WIDTH-1]} - {1'b0, r_b};
    w_div_ge    = ~w_div_trial[WIDTH];
    w_div_rem   = w_div_ge ? w_div_trial[WIDTH-1:0] : {r_acc[WIDTH-2:0], r_a[WIDTH-1]};
    w_div_quo   = {r_a[WIDTH-2:0], w_div_ge};
    case (r_op)
      OP_MUL:  w_final = w_mul_acc;
      OP_DIVU: w_final = w_div_quo;
      default: w_final = w_div_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_count  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_op     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_op  <= ALUOp;
            r_acc <= '0;
            if (w_multi) begin
              r_count <= CW'(WIDTH);
              r_state <= S_BUSY;
            end else begin
              r_result <= w_single;
              r_zero   <= (w_single == '0);
              r_state  <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          r_count <= r_count - 1'b1;
          if (r_op == OP_MUL) begin
            r_acc <= w_mul_acc;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
          end else begin
            r_acc <= w_div_rem;
            r_a   <= w_div_quo;
          end
          // The last iteration happens on the same edge that loads the result.
          if (r_count == CW'(1)) begin
            r_result <= w_final;
            r_zero   <= (w_final == '0);
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_alu_multicycle;

  localparam int W = 64;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   ALUOp;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Result;
  logic         Zero;
  logic [1:0]   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ALUOp     (ALUOp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Zero      (Zero),
    .o_state   (dbg_state)
  );

  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    int sh;
    sh = int'(y % W);
    case (op)
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_NOR:  return ~(x | y);
      OP_XOR:  return x ^ y;
      OP_SLL:  return x << sh;
      OP_SRL:  return x >> sh;
      OP_SRA:  return $unsigned($signed(x) >>> sh);
      OP_SLT:  return ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      OP_SLTU: return (x < y) ? W'(1) : W'(0);
      OP_MUL:  return x * y;
      OP_DIVU: return (y == 0) ? {W{1'b1}} : x / y;
      OP_REMU: return (y == 0) ? x : x % y;
      default: return '0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op);
    return (op == OP_MUL || op == OP_DIVU || op == OP_REMU) ? W + 1 : 1;
  endfunction

  function automatic logic [W-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Driver: starts at a negedge in IDLE, returns result, latency (-1 on timeout)
  // and in_ready as seen in DONE; consumes the result and ends at a negedge.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] res, output logic z, output int lat,
                       output logic rdy_done);
    a = x; b = y; ALUOp = op; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = rand64(); b = rand64(); ALUOp = 4'($urandom_range(0, 15));
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
    res = Result; z = Zero;
    out_ready = 1'b1;
    #1;
    rdy_done = in_ready;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; ALUOp = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || Result !== '0 || Zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: out_valid=%b in_ready=%b Result=%h Zero=%b, want 0 1 0 0",
               out_valid, in_ready, Result, Zero);
    end
  endtask

  task automatic test_add_wrap();
    logic [W-1:0] res; logic z; int lat; logic rd;
    do_op(OP_ADD, {W{1'b1}}, W'(1), res, z, lat, rd);
    n_tests++;
    if (res !== '0 || z !== 1'b1 || lat !== 1) begin
      n_fail++;
      $display("FAIL add_wrap: Result=%h Zero=%b lat=%0d, want 0 1 1", res, z, lat);
    end
  endtask

  task automatic test_legacy();
    logic [3:0]   ops [4] = '{OP_SUB, OP_AND, OP_OR, OP_NOR};
    logic [W-1:0] xs  [4] = '{W'(16), W'(8'hF0), W'(8'hF0), W'(0)};
    logic [W-1:0] ys  [4] = '{W'(3), W'(8'h3C), W'(8'h0F), W'(0)};
    logic [W-1:0] es  [4] = '{W'(13), W'(8'h30), W'(8'hFF), {W{1'b1}}};
    logic [W-1:0] res; logic z; int lat; logic rd;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], xs[i], ys[i], res, z, lat, rd);
      n_tests++;
      if (res !== es[i] || z !== 1'b0 || lat !== 1) begin
        n_fail++;
        $display("FAIL legacy[%0d] op=%b: Result=%h Zero=%b lat=%0d, want %h 0 1",
                 i, ops[i], res, z, lat, es[i]);
      end
    end
  endtask

  task automatic test_shift_cmp();
    logic [3:0]   ops [3] = '{OP_SRA, OP_SLT, OP_SLTU};
    logic [W-1:0] xs  [3] = '{64'h8000_0000_0000_0000, {W{1'b1}}, {W{1'b1}}};
    logic [W-1:0] ys  [3] = '{W'(8'h43), W'(1), W'(1)};
    logic [W-1:0] es  [3] = '{64'hF000_0000_0000_0000, W'(1), W'(0)};
    logic [W-1:0] res; logic z; int lat; logic rd;
    for (int i = 0; i < 3; i++) begin
      do_op(ops[i], xs[i], ys[i], res, z, lat, rd);
      n_tests++;
      if (res !== es[i] || z !== (es[i] == '0) || lat !== 1) begin
        n_fail++;
        $display("FAIL shift_cmp[%0d]: Result=%h Zero=%b lat=%0d, want %h lat 1",
                 i, res, z, lat, es[i]);
      end
    end
  endtask

  task automatic test_mul_stall();
    logic [W-1:0] exp_r;
    int lat;
    int bad;
    exp_r = 64'h3_0000_0003;
    a = 64'h1_0000_0001; b = W'(3); ALUOp = OP_MUL; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      if (lat == 10) begin
        in_valid = 1'b1; ALUOp = OP_ADD; a = W'(5); b = W'(5);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    n_tests++;
    if (!out_valid || lat !== 65 || Result !== exp_r) begin
      n_fail++;
      $display("FAIL mul_latency: out_valid=%b lat=%0d Result=%h, want 1 65 %h",
               out_valid, lat, Result, exp_r);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (Result !== exp_r || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL mul_stall: %0d unstable cycles, last Result=%h out_valid=%b in_ready=%b",
               bad, Result, out_valid, in_ready);
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL done_no_overlap: in_ready=%b with out_ready high in DONE, want 0", in_ready);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL busy_ignore: out_valid=%b in_ready=%b after pop, want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_div();
    logic [3:0]   ops [4] = '{OP_DIVU, OP_REMU, OP_DIVU, OP_REMU};
    logic [W-1:0] xs  [4] = '{W'(100), W'(100), 64'h1234_5678_9ABC_DEF0, W'(5)};
    logic [W-1:0] ys  [4] = '{W'(7), W'(7), W'(0), W'(0)};
    logic [W-1:0] es  [4] = '{W'(14), W'(2), {W{1'b1}}, W'(5)};
    logic [W-1:0] res; logic z; int lat; logic rd;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], xs[i], ys[i], res, z, lat, rd);
      n_tests++;
      if (res !== es[i] || z !== 1'b0 || lat !== 65) begin
        n_fail++;
        $display("FAIL div[%0d]: Result=%h Zero=%b lat=%0d, want %h 0 65",
                 i, res, z, lat, es[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0]   op;
    logic [W-1:0] x, y, er, res;
    logic z, rd;
    int lat;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      x  = rand64();
      case ($urandom_range(0, 3))
        0:       y = '0;
        1:       y = W'($urandom_range(1, 1000));
        2:       y = W'($urandom);
        default: y = rand64();
      endcase
      if ($urandom_range(0, 5) == 0) x = y;
      er = ref_alu(op, x, y);
      do_op(op, x, y, res, z, lat, rd);
      n_tests++;
      if (res !== er || z !== (er == '0) || lat !== ref_lat(op) || rd !== 1'b0) begin
        n_fail++;
        $display("FAIL random[%0d] op=%b a=%h b=%h: Result=%h Zero=%b lat=%0d rdy=%b, want %h %b %0d 0",
                 i, op, x, y, res, z, lat, rd, er, (er == '0), ref_lat(op));
      end
    end
  endtask

  task automatic test_reset_busy();
    logic [W-1:0] res; logic z, rd; int lat, bad;
    a = W'(1000); b = W'(3); ALUOp = OP_DIVU; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || Result !== '0) begin
      n_fail++;
      $display("FAIL reset_busy: out_valid=%b in_ready=%b Result=%h, want 0 1 0",
               out_valid, in_ready, Result);
    end
    bad = 0;
    repeat (70) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_discard: out_valid seen %0d cycles after reset, want 0", bad);
    end
    do_op(OP_ADD, W'(2), W'(2), res, z, lat, rd);
    n_tests++;
    if (res !== W'(4) || z !== 1'b0 || lat !== 1) begin
      n_fail++;
      $display("FAIL add_after_reset: Result=%h Zero=%b lat=%0d, want 4 0 1", res, z, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] res; logic z, rd; int lat;
    for (int i = 0; i < 3; i++) begin
      do_op(OP_XOR, W'(i), W'(i + 1), res, z, lat, rd);
      n_tests++;
      if (res !== (W'(i) ^ W'(i + 1)) || rd !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: Result=%h rdy_in_done=%b in_ready_after=%b, want %h 0 1",
                 i, res, rd, in_ready, W'(i) ^ W'(i + 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_legacy();
    test_shift_cmp();
    test_mul_stall();
    test_div();
    test_back_to_back();
    test_random();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
